// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard controller: register-address width,
// divide state encoding and the nonzero-register match helper.
package hazard_unit_pkg;

   localparam int REG_SIZE = 5;

   typedef logic [REG_SIZE-1:0] regAddr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divState_t;

   // $0 is hard-wired to zero, so a match on it is never a real dependency.
   function automatic logic regHit(input regAddr_t a, input regAddr_t b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_div_fsm.sv
// Divide occupancy tracker: holds Execute for DIV_CYCLES cycles per divide
// and flags the single cycle in which the HI/LO result is valid.
module hazard_div_fsm
   import hazard_unit_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic divStartE,
   output logic divStall,
   output logic divReady
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

   divState_t     state, stateNext;
   logic [CW-1:0] cnt, cntNext;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves a variable unassigned and no latch is inferred.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      divStall  = 1'b0;
      divReady  = 1'b0;
      case (state)
         IDLE: begin
            divStall = divStartE;
            if (divStartE) begin
               cntNext   = CNT_LOAD;
               stateNext = BUSY;
            end
         end
         BUSY: begin
            divStall = 1'b1;
            cntNext  = cnt - CW'(1);
            if (cnt == CW'(1)) stateNext = DONE;
         end
         DONE: begin
            // The finishing divide still occupies E, so divStartE is its own.
            divReady  = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: load-use, branch/jr operand and
// divide-occupancy stalls, pipeline flush controls and a stall-cycle counter.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_SIZE-1:0] rsD,
   input  logic [REG_SIZE-1:0] rtD,
   input  logic                branchD,
   input  logic                jrD,
   input  logic [REG_SIZE-1:0] rtE,
   input  logic [REG_SIZE-1:0] writeRegAddrE,
   input  logic                Regfile_weE,
   input  logic                memtoRegE,
   input  logic                divStartE,
   input  logic [REG_SIZE-1:0] writeRegAddrM,
   input  logic                memtoRegM,
   output logic                stallF,
   output logic                stallD,
   output logic                stallE,
   output logic                flushE,
   output logic                flushM,
   output logic                divReady,
   output logic [CNT_W-1:0]    stallCount
);

   logic lwStall, brStall, divStall;
   logic eHitRs, eHitRt, mHitRs, mHitRt;
   logic anyStall;

   hazard_div_fsm #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_divFsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .divStartE(divStartE),
      .divStall (divStall),
      .divReady (divReady)
   );

   assign lwStall = memtoRegE & (regHit(rtE, rsD) | regHit(rtE, rtD));

   // Decode compares need the value now: an ALU result still in E or a load
   // still in M cannot be forwarded into the comparator in time.
   assign eHitRs = Regfile_weE & regHit(writeRegAddrE, rsD);
   assign eHitRt = Regfile_weE & regHit(writeRegAddrE, rtD);
   assign mHitRs = memtoRegM   & regHit(writeRegAddrM, rsD);
   assign mHitRt = memtoRegM   & regHit(writeRegAddrM, rtD);

   assign brStall = (branchD & (eHitRs | eHitRt | mHitRs | mHitRt))
                  | (jrD     & (eHitRs | mHitRs));

   // Outputs are forced low while reset is asserted, independent of inputs.
   assign anyStall = rst_n & (lwStall | brStall | divStall);
   assign stallF   = anyStall;
   assign stallD   = anyStall;
   assign stallE   = rst_n & divStall;
   assign flushM   = rst_n & divStall;
   // A frozen ID/EX holds the divide; flushing it would drop the instruction.
   assign flushE   = rst_n & (lwStall | brStall) & ~divStall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCount <= '0;
      end else if (stallF && (stallCount != '1)) begin
         stallCount <= stallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with DIV_CYCLES=4 and CNT_W=4.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rsD, rtD, rtE, writeRegAddrE, writeRegAddrM;
   logic       branchD, jrD, Regfile_weE, memtoRegE, divStartE, memtoRegM;
   logic       stallF, stallD, stallE, flushE, flushM, divReady;
   logic [3:0] stallCount;

   int vectors     = 0;
   int miscompares = 0;

   // {stallF, stallD, stallE, flushE, flushM, divReady}
   wire [5:0] outs = {stallF, stallD, stallE, flushE, flushM, divReady};
   localparam logic [5:0] ZERO    = 6'b000000;
   localparam logic [5:0] LU      = 6'b110100;
   localparam logic [5:0] DIV     = 6'b111010;
   localparam logic [5:0] READY   = 6'b000001;
   localparam logic [5:0] READYLU = 6'b110101;

   hazard_unit #(
      .DIV_CYCLES(4),
      .CNT_W     (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rsD          (rsD),
      .rtD          (rtD),
      .branchD      (branchD),
      .jrD          (jrD),
      .rtE          (rtE),
      .writeRegAddrE(writeRegAddrE),
      .Regfile_weE  (Regfile_weE),
      .memtoRegE    (memtoRegE),
      .divStartE    (divStartE),
      .writeRegAddrM(writeRegAddrM),
      .memtoRegM    (memtoRegM),
      .stallF       (stallF),
      .stallD       (stallD),
      .stallE       (stallE),
      .flushE       (flushE),
      .flushM       (flushM),
      .divReady     (divReady),
      .stallCount   (stallCount)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clearInputs();
      rsD = 0; rtD = 0; rtE = 0; writeRegAddrE = 0; writeRegAddrM = 0;
      branchD = 0; jrD = 0; Regfile_weE = 0; memtoRegE = 0;
      divStartE = 0; memtoRegM = 0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at a negedge with reset released and inputs idle.
   task automatic applyReset();
      rst_n = 1'b0;
      clearInputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clearInputs();
      memtoRegE = 1; rtE = 5; rsD = 5; divStartE = 1;
      #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL reset_outs: got %b expected %b", outs, ZERO);
      end
      vectors++;
      if (stallCount !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d expected 0", stallCount);
      end
      @(posedge clk); #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL reset_held: got %b expected %b", outs, ZERO);
      end
      applyReset();
   endtask

   task automatic test_load_use();
      applyReset();
      memtoRegE = 1; rtE = 5; rsD = 5; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL lu_rs: got %b expected %b", outs, LU);
      end
      nextCycle();
      rsD = 0; rtD = 7; rtE = 7; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL lu_rt: got %b expected %b", outs, LU);
      end
      vectors++;
      if (stallCount !== 4'd1) begin
         miscompares++;
         $display("FAIL lu_count: got %0d expected 1", stallCount);
      end
      nextCycle();
      rtE = 0; rsD = 0; rtD = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL lu_r0: got %b expected %b", outs, ZERO);
      end
      memtoRegE = 0; rtE = 5; rsD = 5; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL lu_noload: got %b expected %b", outs, ZERO);
      end
   endtask

   task automatic test_branch();
      applyReset();
      branchD = 1; Regfile_weE = 1; writeRegAddrE = 8; rtD = 8; rsD = 3; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL br_alu_rt: got %b expected %b", outs, LU);
      end
      branchD = 0; jrD = 1; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL jr_rt_only: got %b expected %b", outs, ZERO);
      end
      rsD = 8; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL jr_rs: got %b expected %b", outs, LU);
      end
      jrD = 0; branchD = 1; Regfile_weE = 0; writeRegAddrE = 0;
      memtoRegM = 1; writeRegAddrM = 9; rsD = 9; rtD = 2; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL br_load_m: got %b expected %b", outs, LU);
      end
      memtoRegM = 0; Regfile_weE = 1; writeRegAddrE = 9; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL br_alu_rs: got %b expected %b", outs, LU);
      end
      Regfile_weE = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL br_nowrite: got %b expected %b", outs, ZERO);
      end
      Regfile_weE = 1; writeRegAddrE = 0; rsD = 0; rtD = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL br_r0: got %b expected %b", outs, ZERO);
      end
   endtask

   task automatic test_lw_and_br();
      applyReset();
      memtoRegE = 1; rtE = 5; rsD = 5;
      branchD = 1; Regfile_weE = 1; writeRegAddrE = 5;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (outs !== LU) begin
            miscompares++;
            $display("FAIL lwbr_%0d: got %b expected %b", i, outs, LU);
         end
         nextCycle();
      end
      clearInputs(); #1;
      vectors++;
      if (stallCount !== 4'd3) begin
         miscompares++;
         $display("FAIL lwbr_count: got %0d expected 3", stallCount);
      end
   endtask

   task automatic test_divide();
      applyReset();
      divStartE = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (outs !== DIV) begin
            miscompares++;
            $display("FAIL div_stall_%0d: got %b expected %b", i, outs, DIV);
         end
         nextCycle();
      end
      #1;
      vectors++;
      if (outs !== READY) begin
         miscompares++;
         $display("FAIL div_ready: got %b expected %b", outs, READY);
      end
      nextCycle();
      divStartE = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL div_idle: got %b expected %b", outs, ZERO);
      end
      vectors++;
      if (stallCount !== 4'd4) begin
         miscompares++;
         $display("FAIL div_count: got %0d expected 4", stallCount);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp;
      applyReset();
      divStartE = 1;
      for (int i = 0; i < 10; i++) begin
         exp = (i == 4 || i == 9) ? READY : DIV;
         #1;
         vectors++;
         if (outs !== exp) begin
            miscompares++;
            $display("FAIL b2b_%0d: got %b expected %b", i, outs, exp);
         end
         nextCycle();
      end
      divStartE = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL b2b_idle: got %b expected %b", outs, ZERO);
      end
      vectors++;
      if (stallCount !== 4'd8) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d expected 8", stallCount);
      end
   endtask

   task automatic test_div_load_use();
      applyReset();
      divStartE = 1; memtoRegE = 1; rtE = 5; rsD = 5;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (outs !== DIV) begin
            miscompares++;
            $display("FAIL divlu_busy_%0d: got %b expected %b", i, outs, DIV);
         end
         nextCycle();
      end
      #1;
      vectors++;
      if (outs !== READYLU) begin
         miscompares++;
         $display("FAIL divlu_done: got %b expected %b", outs, READYLU);
      end
      nextCycle();
      divStartE = 0; #1;
      vectors++;
      if (outs !== LU) begin
         miscompares++;
         $display("FAIL divlu_after: got %b expected %b", outs, LU);
      end
      vectors++;
      if (stallCount !== 4'd5) begin
         miscompares++;
         $display("FAIL divlu_count: got %0d expected 5", stallCount);
      end
   endtask

   task automatic test_reset_mid_divide();
      logic [5:0] exp;
      applyReset();
      divStartE = 1;
      nextCycle();
      nextCycle();
      #1;
      vectors++;
      if (outs !== DIV) begin
         miscompares++;
         $display("FAIL mid_busy: got %b expected %b", outs, DIV);
      end
      rst_n = 1'b0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL mid_async: got %b expected %b", outs, ZERO);
      end
      vectors++;
      if (stallCount !== 4'd0) begin
         miscompares++;
         $display("FAIL mid_count: got %0d expected 0", stallCount);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp = (i == 4) ? READY : DIV;
         #1;
         vectors++;
         if (outs !== exp) begin
            miscompares++;
            $display("FAIL mid_redo_%0d: got %b expected %b", i, outs, exp);
         end
         nextCycle();
      end
      divStartE = 0; #1;
      vectors++;
      if (outs !== ZERO) begin
         miscompares++;
         $display("FAIL mid_idle: got %b expected %b", outs, ZERO);
      end
   endtask

   task automatic test_saturation();
      int exp;
      applyReset();
      memtoRegE = 1; rtE = 5; rsD = 5;
      for (int i = 0; i < 20; i++) begin
         exp = (i > 15) ? 15 : i;
         #1;
         vectors++;
         if (stallCount !== 4'(exp)) begin
            miscompares++;
            $display("FAIL sat_%0d: got %0d expected %0d", i, stallCount, exp);
         end
         nextCycle();
      end
      clearInputs();
      nextCycle(); #1;
      vectors++;
      if (stallCount !== 4'd15) begin
         miscompares++;
         $display("FAIL sat_hold: got %0d expected 15", stallCount);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_lw_and_br();
      test_divide();
      test_back_to_back();
      test_div_load_use();
      test_reset_mid_divide();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding logic and covers the hazards forwarding cannot resolve:
- load-use stalls;
- branch/jr operand stalls in Decode;
- multi-cycle divide occupancy of Execute, via a small state machine.

It drives the stall/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DIV_CYCLES, 32, total stall cycles per divide; legal range ≥ 2.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- rsD, rtD  in  5 each  source registers of the instruction in Decode
- branchD  in  1  beq/bne in Decode (compares rs, rt)
- jrD  in  1  jr/jalr in Decode (reads rs only)
- rtE  in  5  rt of the instruction in Execute
- writeRegAddrE  in  5  destination register in Execute
- Regfile_weE  in  1  Execute instruction writes the register file
- memtoRegE  in  1  Execute instruction is a load
- divStartE  in  1  div/divu in Execute
- writeRegAddrM  in  5  destination register in Memory
- memtoRegM  in  1  Memory instruction is a load
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID
- stallE  out  1  hold ID/EX
- flushE  out  1  insert bubble into ID/EX
- flushM  out  1  insert bubble into EX/MEM
- divReady  out  1  divide result valid this cycle (HI/LO write enable)
- stallCount  out  CNT_W  cycles with stallF=1, saturating

## Operation
Register $0 never causes a hazard. Every comparison requires a nonzero address.

Hazard terms:
- **lwstall** = memtoRegE & (rtE==rsD | rtE==rtD).
- **brstall**:
  - branchD & ((Regfile_weE & writeRegAddrE∈{rsD,rtD}) | (memtoRegM & writeRegAddrM∈{rsD,rtD}));
  - or the same terms with jrD in place of branchD, matching rsD only.

Divide state machine, states IDLE, BUSY, DONE. The counter is cnt, width $clog2(DIV_CYCLES).
- **IDLE**:
  - divstall = divStartE.
  - If divStartE: load cnt = DIV_CYCLES-1 and go to BUSY.
- **BUSY**:
  - divstall = 1 and cnt decrements.
  - When cnt==1, go to DONE.
- **DONE**:
  - divstall = 0 and divReady = 1.
  - divStartE is ignored; the same divide is still in E and leaves at the end of this cycle.
  - Always go to IDLE.

Output equations:
- stallF = stallD = lwstall | brstall | divstall.
- stallE = divstall.
- flushM = divstall. The divide is frozen in E, so M receives bubbles.
- flushE = (lwstall | brstall) & ~divstall. A frozen ID/EX is never flushed, so the divide cannot be lost.

stallCount increments on every cycle with stallF=1 and holds at all-ones.

## Timing
- Reset: all outputs are 0, the state is IDLE, cnt = 0 and stallCount = 0. Reset takes effect immediately, including mid-divide; the next cycle starts in IDLE.
- Hazard outputs are combinational from the current inputs and state, with zero latency.
- A divide entering E in cycle t:
  - stallE/stallF/stallD/flushM are 1 for cycles t..t+DIV_CYCLES-1;
  - divReady = 1 in cycle t+DIV_CYCLES;
  - all divide stalls are 0 in that cycle.
- Back-to-back divides: the second divide reaches E one cycle after DONE and re-enters BUSY from IDLE. There is exactly one unstalled cycle (DONE) between the two divides.
- Simultaneous lwstall/brstall with divstall: stalls are ORed and flushE is suppressed. The load-use or branch hazard is re-evaluated after the divide releases.
- Simultaneous lwstall and brstall: a single flushE; no double counting in stallCount.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the REG_SIZE register-address width define, which is already used by the forwarding logic.
- One sub-module, hazard_div_fsm. It owns the state, cnt, divstall and divReady.
- The hazard equations, output combination and stallCount live in the top level.

## Test plan
- Load-use: memtoRegE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, stallE=0. With rtE=0 and rsD=0 → all outputs 0.
- Branch after ALU op: branchD=1, Regfile_weE=1, writeRegAddrE=8, rtD=8 → stall plus flushE. jrD=1 with rtD=8 only (rsD≠8) → no stall.
- Divide, DIV_CYCLES=4: divStartE held from cycle t → stallE=flushM=1 for t..t+3, divReady=1 at t+4, IDLE at t+5.
- Divide plus load-use during BUSY: memtoRegE=1 with matching rsD → stallF=1, flushE=0 throughout BUSY. After DONE, flushE=1 if the hazard persists.
- Reset mid-divide: deassert rst_n at cnt=2 → all outputs 0 asynchronously. After release, the state is IDLE and a new divide takes the full DIV_CYCLES.
- Counter saturation: CNT_W=4, stall held 20 cycles → stallCount reaches 15 and holds.
